// File: rtl/nrisc_demux_pkg.sv
// Shared defaults and elaboration helpers for the registered NRISC demux.
package nrisc_demux_pkg;

    localparam int TAM_DEF   = 16;
    localparam int NCH_DEF   = 16;
    localparam int SEL_W_DEF = 4;
    localparam int ERR_W_DEF = 8;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // True when a SEL_W-bit select can address every one of NCH channels.
    function automatic bit sel_fits(input int nch, input int sel_w);
        return (clog2(nch) <= sel_w) && (nch >= 2) && (nch <= 16);
    endfunction

endpackage

// File: rtl/nrisc_demux_slot.sv
// One-entry holding register for a single demux channel.
// The slot is free when empty or when its consumer takes the word this
// cycle, so a drain and a refill can share one clock edge.
module nrisc_demux_slot
    import nrisc_demux_pkg::*;
#(
    parameter int TAM = TAM_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_i,
    input  logic [TAM-1:0] data_i,
    input  logic           ready_i,
    output logic           valid_o,
    output logic [TAM-1:0] data_o,
    output logic           free_o
);

    logic           valid_q;
    logic [TAM-1:0] data_q;

    // Load has priority over drain; a drained slot returns its data to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign free_o  = ~valid_q | ready_i;

endmodule

// File: rtl/nrisc_demux_pipe.sv
// Registered 1-to-NCH demultiplexer with per-channel valid/ready holding
// registers, broadcast, and a saturating counter for dropped unicasts.
//
// Handshake: a word moves when valid & ready are both high at a rising
// clk edge; valid never depends on ready, and a held word stays stable
// until its consumer raises ready. in_ready is a function of out_ready,
// in_sel and in_bcast only.
module nrisc_demux_pipe
    import nrisc_demux_pkg::*;
#(
    parameter int TAM   = TAM_DEF,
    parameter int NCH   = NCH_DEF,
    parameter int SEL_W = SEL_W_DEF,
    parameter int ERR_W = ERR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [TAM-1:0]     in_data,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_bcast,
    output logic [NCH-1:0]     out_valid,
    input  logic [NCH-1:0]     out_ready,
    output logic [NCH*TAM-1:0] out_data,
    output logic               err_pulse,
    output logic [ERR_W-1:0]   err_cnt
);

    generate
        if (!sel_fits(NCH, SEL_W)) begin : g_bad_params
            $error("nrisc_demux_pipe: need 2 <= NCH <= 16 and 2^SEL_W >= NCH");
        end
    endgenerate

    localparam int              NSEL  = 1 << SEL_W;
    localparam logic [SEL_W:0]  NCH_L = (SEL_W + 1)'(NCH);

    logic [NCH-1:0]   slot_load;
    logic [NCH-1:0]   slot_free;
    logic [NSEL-1:0]  free_ext;
    logic             acc;
    logic             sel_in_range;
    logic             err_hit;
    logic             err_pulse_q;
    logic [ERR_W-1:0] err_cnt_q;
    logic [ERR_W-1:0] err_cnt_d;

    assign sel_in_range = ({1'b0, in_sel} < NCH_L);

    // Unused select codes read as always free, so dropped words never stall.
    always_comb begin
        free_ext = '1;
        for (int i = 0; i < NCH; i++) begin
            free_ext[i] = slot_free[i];
        end
    end

    assign in_ready = in_bcast ? (&slot_free) : free_ext[in_sel];
    assign acc      = in_valid & in_ready;
    assign err_hit  = acc & ~in_bcast & ~sel_in_range;

    // Select decode: broadcast loads every slot, unicast only the addressed one.
    always_comb begin
        slot_load = '0;
        for (int i = 0; i < NCH; i++) begin
            slot_load[i] = acc & (in_bcast | (in_sel == SEL_W'(i)));
        end
    end

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_slot
            nrisc_demux_slot #(.TAM(TAM)) u_slot (
                .clk     (clk),
                .rst     (rst),
                .load_i  (slot_load[g]),
                .data_i  (in_data),
                .ready_i (out_ready[g]),
                .valid_o (out_valid[g]),
                .data_o  (out_data[g*TAM +: TAM]),
                .free_o  (slot_free[g])
            );
        end
    endgenerate

    // Saturating increment: stops at all-ones, never wraps.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_hit && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    // Error pulse and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            err_pulse_q <= err_hit;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_nrisc_demux_pipe.sv
// Bench for nrisc_demux_pipe: a 16-channel instance with a scoreboard
// monitor, plus a 12-channel / 2-bit-counter instance for drop handling.
module tb_nrisc_demux_pipe;

  logic         clk;
  logic         rst;

  // Main instance: NCH = 16, ERR_W = 8
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  in_data;
  logic [3:0]   in_sel;
  logic         in_bcast;
  logic [15:0]  out_valid;
  logic [15:0]  out_ready;
  logic [255:0] out_data;
  logic         err_pulse;
  logic [7:0]   err_cnt;

  // Second instance: NCH = 12, ERR_W = 2
  logic         b_in_valid;
  logic         b_in_ready;
  logic [15:0]  b_in_data;
  logic [3:0]   b_in_sel;
  logic         b_in_bcast;
  logic [11:0]  b_out_valid;
  logic [11:0]  b_out_ready;
  logic [191:0] b_out_data;
  logic         b_err_pulse;
  logic [1:0]   b_err_cnt;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [15:0] exp_q[16][$];

  nrisc_demux_pipe #(.TAM(16), .NCH(16), .SEL_W(4), .ERR_W(8)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_bcast  (in_bcast),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt)
  );

  nrisc_demux_pipe #(.TAM(16), .NCH(12), .SEL_W(4), .ERR_W(2)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .in_sel    (b_in_sel),
    .in_bcast  (b_in_bcast),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .err_pulse (b_err_pulse),
    .err_cnt   (b_err_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ch_data(input int ch);
    return out_data[ch*16 +: 16];
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      for (int ch = 0; ch < 16; ch++) exp_q[ch].delete();
    end else begin
      for (int ch = 0; ch < 16; ch++) begin
        chk_cnt++;
        if (out_valid[ch]) begin
          if (exp_q[ch].size() == 0)
            $display("FAIL mon_unexpected ch%0d: got %h, no word expected", ch, ch_data(ch));
          else if (ch_data(ch) !== exp_q[ch][0])
            $display("FAIL mon_data ch%0d: got %h, expected %h", ch, ch_data(ch), exp_q[ch][0]);
          else
            pass_cnt++;
          if (out_ready[ch] && exp_q[ch].size() > 0) void'(exp_q[ch].pop_front());
        end else begin
          if (ch_data(ch) !== 16'h0000)
            $display("FAIL mon_idle_data ch%0d: got %h, expected 0000", ch, ch_data(ch));
          else
            pass_cnt++;
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [3:0] sel, input logic [15:0] data,
                      input logic bcast, input bit rand_rdy, output int stalls);
    bit done;
    done     = 1'b0;
    stalls   = 0;
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
    in_bcast = bcast;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        if (bcast) begin
          for (int ch = 0; ch < 16; ch++) exp_q[ch].push_back(data);
        end else begin
          exp_q[sel].push_back(data);
        end
        done = 1'b1;
      end else begin
        stalls++;
      end
      @(posedge clk); #1;
      if (!done) begin
        if (stalls > 100) begin
          chk_cnt++;
          $display("FAIL send_timeout sel=%0d bcast=%0b: waited %0d cycles, required acceptance", sel, bcast, stalls);
          done = 1'b1;
        end else if (rand_rdy) begin
          out_ready = (stalls > 4) ? 16'hFFFF : 16'($urandom);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b1; in_data = 16'h5555; in_sel = 4'd0; in_bcast = 1'b0;
    out_ready = 16'hFFFF;
    b_in_valid = 1'b0; b_in_data = 16'h0; b_in_sel = 4'd0; b_in_bcast = 1'b0;
    b_out_ready = 12'hFFF;
    repeat (3) begin
      @(negedge clk);
      chk_cnt++;
      if (out_valid !== 16'h0 || out_data !== 256'h0 || err_cnt !== 8'h0 || err_pulse !== 1'b0)
        $display("FAIL reset_hold: valid=%h err_cnt=%0d pulse=%b, required all zero", out_valid, err_cnt, err_pulse);
      else pass_cnt++;
      @(posedge clk);
    end
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk_cnt++;
      if (out_valid !== 16'h0 || out_data !== 256'h0 || b_out_valid !== 12'h0 || b_err_cnt !== 2'd0)
        $display("FAIL reset_release: valid=%h b_valid=%h, required 0 before any accept", out_valid, b_out_valid);
      else pass_cnt++;
      @(posedge clk);
    end
    #1;
  endtask

  task automatic test_unicast_sweep;
    int st;
    out_ready = 16'hFFFF;
    for (int s = 0; s < 16; s++) begin
      send(4'(s), 16'hA000 + 16'(s), 1'b0, 1'b0, st);
      chk_cnt++;
      if (st != 0) $display("FAIL sweep_ready sel=%0d: stalled %0d cycles, required 0", s, st);
      else pass_cnt++;
      chk_cnt++;
      if (out_valid !== (16'h1 << s) || ch_data(s) !== 16'hA000 + 16'(s))
        $display("FAIL sweep_out sel=%0d: valid=%h data=%h, required valid=%h data=%h",
                 s, out_valid, ch_data(s), 16'h1 << s, 16'hA000 + 16'(s));
      else pass_cnt++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_pressure;
    int st;
    out_ready = 16'hFFDF;
    send(4'd5, 16'h1234, 1'b0, 1'b0, st);
    in_valid = 1'b1; in_sel = 4'd5; in_data = 16'h5678; in_bcast = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk_cnt++;
      if (in_ready !== 1'b0 || out_valid[5] !== 1'b1 || ch_data(5) !== 16'h1234)
        $display("FAIL bp_stall cyc%0d: in_ready=%b valid5=%b data5=%h, required 0/1/1234",
                 c, in_ready, out_valid[5], ch_data(5));
      else pass_cnt++;
      @(posedge clk); #1;
    end
    out_ready[5] = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (in_ready !== 1'b1) $display("FAIL bp_release: in_ready=%b, required 1", in_ready);
    else pass_cnt++;
    if (in_ready) exp_q[5].push_back(16'h5678);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_cnt++;
    if (out_valid !== 16'h0020 || ch_data(5) !== 16'h5678)
      $display("FAIL bp_second: valid=%h data5=%h, required 0020/5678", out_valid, ch_data(5));
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_broadcast;
    int st;
    out_ready = 16'h0000;
    send(4'd9, 16'hBEEF, 1'b1, 1'b0, st);
    chk_cnt++;
    if (out_valid !== 16'hFFFF || out_data !== {16{16'hBEEF}})
      $display("FAIL bcast_fill: valid=%h data0=%h data15=%h, required FFFF/BEEF", out_valid, ch_data(0), ch_data(15));
    else pass_cnt++;
    out_ready = 16'hFFF7;
    in_valid = 1'b1; in_bcast = 1'b1; in_sel = 4'd3; in_data = 16'hCAFE;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk_cnt++;
      if (in_ready !== 1'b0) $display("FAIL bcast_block cyc%0d: in_ready=%b, required 0", c, in_ready);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    chk_cnt++;
    if (out_valid !== 16'h0008 || ch_data(3) !== 16'hBEEF)
      $display("FAIL bcast_drain: valid=%h data3=%h, required 0008/BEEF", out_valid, ch_data(3));
    else pass_cnt++;
    out_ready[3] = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (in_ready !== 1'b1) $display("FAIL bcast_release: in_ready=%b, required 1", in_ready);
    else pass_cnt++;
    if (in_ready) for (int ch = 0; ch < 16; ch++) exp_q[ch].push_back(16'hCAFE);
    @(posedge clk); #1;
    in_valid = 1'b0; in_bcast = 1'b0;
    chk_cnt++;
    if (out_valid !== 16'hFFFF || out_data !== {16{16'hCAFE}})
      $display("FAIL bcast_second: valid=%h data7=%h, required FFFF/CAFE", out_valid, ch_data(7));
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_out_of_range;
    logic [1:0] exp_cnt;
    exp_cnt = 2'd0;
    b_out_ready = 12'hFFF;
    for (int k = 0; k < 5; k++) begin
      b_in_valid = 1'b1; b_in_sel = 4'd13; b_in_bcast = 1'b0; b_in_data = 16'($urandom);
      @(negedge clk);
      chk_cnt++;
      if (b_in_ready !== 1'b1) $display("FAIL oor_ready k=%0d: got %b, required 1", k, b_in_ready);
      else pass_cnt++;
      @(posedge clk); #1;
      if (exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
      chk_cnt++;
      if (b_err_pulse !== 1'b1 || b_err_cnt !== exp_cnt || b_out_valid !== 12'h0)
        $display("FAIL oor_drop k=%0d: pulse=%b cnt=%0d valid=%h, required 1/%0d/000",
                 k, b_err_pulse, b_err_cnt, b_out_valid, exp_cnt);
      else pass_cnt++;
    end
    b_in_valid = 1'b0;
    @(posedge clk); #1;
    chk_cnt++;
    if (b_err_pulse !== 1'b0 || b_err_cnt !== 2'd3)
      $display("FAIL oor_idle: pulse=%b cnt=%0d, required 0/3", b_err_pulse, b_err_cnt);
    else pass_cnt++;
    // Broadcast with an out-of-range select is never an error.
    b_out_ready = 12'h000;
    b_in_valid = 1'b1; b_in_bcast = 1'b1; b_in_sel = 4'd13; b_in_data = 16'h0BCD;
    @(posedge clk); #1;
    b_in_valid = 1'b0; b_in_bcast = 1'b0;
    chk_cnt++;
    if (b_out_valid !== 12'hFFF || b_err_pulse !== 1'b0 || b_out_data[11*16 +: 16] !== 16'h0BCD)
      $display("FAIL oor_bcast: valid=%h pulse=%b data11=%h, required FFF/0/0BCD",
               b_out_valid, b_err_pulse, b_out_data[11*16 +: 16]);
    else pass_cnt++;
    b_out_ready = 12'hFFF;
    @(posedge clk); #1;
    b_in_valid = 1'b1; b_in_sel = 4'd11; b_in_data = 16'h1111;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    chk_cnt++;
    if (b_out_valid !== 12'h800 || b_err_pulse !== 1'b0 || b_out_data[11*16 +: 16] !== 16'h1111)
      $display("FAIL b_unicast11: valid=%h pulse=%b data=%h, required 800/0/1111",
               b_out_valid, b_err_pulse, b_out_data[11*16 +: 16]);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    int st;
    for (int n = 0; n < 200; n++) begin
      out_ready = 16'($urandom);
      send(4'($urandom_range(0, 15)), 16'($urandom), ($urandom_range(0, 7) == 0), 1'b1, st);
    end
    out_ready = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1;
    for (int ch = 0; ch < 16; ch++) begin
      chk_cnt++;
      if (exp_q[ch].size() != 0) $display("FAIL rand_leftover ch%0d: %0d words never seen, required 0", ch, exp_q[ch].size());
      else pass_cnt++;
    end
  endtask

  task automatic test_async_reset;
    int st;
    out_ready = 16'h0000;
    send(4'd2, 16'h2222, 1'b0, 1'b0, st);
    send(4'd7, 16'h7777, 1'b0, 1'b0, st);
    chk_cnt++;
    if (out_valid !== 16'h0084) $display("FAIL ares_pre: valid=%h, required 0084", out_valid);
    else pass_cnt++;
    #1 rst = 1'b1;
    #1;
    chk_cnt++;
    if (out_valid !== 16'h0 || out_data !== 256'h0)
      $display("FAIL ares_clear: valid=%h data2=%h, required 0 without a clock edge", out_valid, ch_data(2));
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 16'hFFFF;
    repeat (2) begin
      @(posedge clk); #1;
      chk_cnt++;
      if (out_valid !== 16'h0) $display("FAIL ares_after: valid=%h, required 0", out_valid);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_unicast_sweep();
    test_back_pressure();
    test_broadcast();
    test_out_of_range();
    test_random();
    chk_cnt++;
    if (err_cnt !== 8'h0) $display("FAIL main_err_cnt: got %0d, required 0", err_cnt);
    else pass_cnt++;
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
